mig_ui_responder: RTL
=====================

// Module: mig_ui_responder
// PURPOSE
// - BRAM-backed responder for the MIG 7-series user (app_*) interface; stands in for the sdram core
//   so the mux_mem-to-DDR3 adapter runs in simulation and on boards without DDR3.
// - Accepts the adapter's commands and write data and returns read data with MIG-like timing
//   (calibration delay, app_rdy stalls, decoupled write-data FIFO, fixed read latency).
// PARAMETERS
// - ADDR_WIDTH      29   app_addr width, in 16-bit DQ-word units
// - APP_DATA_WIDTH  128  one BL8 line; mask width = APP_DATA_WIDTH/8
// - DEPTH_LOG2      10   log2 of BRAM lines (1024 x 128b = 16 KiB)
// - CALIB_CYCLES    64   cycles from reset release to init_calib_complete
// - RD_LATENCY      4    cycles from read dequeue to app_rd_data_valid; legal range >= 2
// - FIFO_DEPTH      4    entries in the command FIFO and in the write-data FIFO; power of 2
// - STALL_PERIOD    0    app_rdy forced low 1 cycle in every STALL_PERIOD (refresh emulation); 0 = off
// PORTS
// - clk                  in   1    ui clock; all logic on rising edge
// - rst                  in   1    asynchronous, active-low reset
// - app_addr             in   29   line address; bits [2:0] ignored, line = app_addr[DEPTH_LOG2+2:3]
// - app_cmd              in   3    3'b000 write, 3'b001 read
// - app_en               in   1    command strobe
// - app_rdy              out  1    command accepted when app_en & app_rdy
// - app_wdf_data         in   128  write data
// - app_wdf_mask         in   16   1 = byte NOT written; bit i masks data[8i+7:8i]
// - app_wdf_wren         in   1    write data valid
// - app_wdf_end          in   1    last beat; always 1 (single-beat lines); ignored
// - app_wdf_rdy          out  1    write data accepted when app_wdf_wren & app_wdf_rdy
// - app_rd_data          out  128  read data
// - app_rd_data_valid    out  1    app_rd_data valid this cycle; no backpressure
// - app_rd_data_end      out  1    equals app_rd_data_valid
// - init_calib_complete  out  1    calibration done; stays high until reset
// BEHAVIOUR
// - Reset: all outputs 0, FIFOs empty, read pipe empty, calib and stall counters 0.
// - Calibration FSM: CALIB -> RUN when the counter reaches CALIB_CYCLES-1. RUN is terminal until reset.
// - app_rdy     = RUN & !cmd_full & !stall. Combinational from state. Never depends on app_en.
// - app_wdf_rdy = RUN & !wdf_full.
// - Commands and write data are independent:
//   - write data may precede its command, coincide with it or follow it;
//   - write data is paired with write commands strictly in order.
// - In RUN, one cmd-FIFO head is executed per cycle, strictly in order:
//   - read: dequeue; issue the BRAM read; data returned RD_LATENCY cycles later.
//   - write: dequeue only if wdf is non-empty, pop both in the same cycle, then a byte-masked BRAM write.
//     If wdf is empty the head blocks, and reads behind it wait.
//   - any other app_cmd value: accepted and dropped in one cycle; no data returned, no wdf pop.
// - Read-after-write: a read dequeued on the cycle after a write returns the new data (no bypass hazard).
// - Read pipe: shift register of valid bits plus a BRAM output register.
//   - Back-to-back reads give back-to-back valid, one per cycle, in order.
// - Simultaneous push and pop on a full FIFO: the pop frees the slot, but the push is refused
//   because app_rdy/app_wdf_rdy was already low.
// - Stall: a counter wraps at STALL_PERIOD-1; stall = 1 on the wrap cycle. The counter runs only in RUN.
// - Address beyond BRAM depth: upper bits are discarded, so the access wraps modulo 2^DEPTH_LOG2 lines.
// - Reset asserted mid-operation:
//   - pending commands, write data and in-flight reads are discarded, and valid drops immediately;
//   - BRAM contents are not cleared;
//   - calibration is rerun.
// STRUCTURE
// - Package gba_io_mig_pkg:
//   - MIG_CMD_WRITE / MIG_CMD_READ constants;
//   - APP_DATA_WIDTH, APP_MASK_WIDTH and ADDR_WIDTH localparams, shared with mem.
// - Sub-module sync_fifo #(WIDTH, DEPTH):
//   - instantiated twice: cmd FIFO {cmd, addr} and wdf FIFO {mask, data};
//   - full/empty flags come from a count register.
// - Top level contains the calibration FSM, the stall counter, the executor, the BRAM array
//   (inferred, byte-enable write) and the read pipe.
// TESTING
// - Reset release:
//   - init_calib_complete rises exactly CALIB_CYCLES cycles later;
//   - app_rdy and app_wdf_rdy stay 0 before that.
// - Write 0x00112233_44556677_8899AABB_CCDDEEFF to addr 0x10, mask 0, data with the command
//   -> a read of 0x10 returns the same value RD_LATENCY cycles after dequeue.
// - Byte mask: write 0xFF..FF at addr 0x20, then write 0 with mask 16'hFFFE
//   -> the read returns 0xFF..FF00 (only byte 0 changed).
// - Data 3 cycles after the command, with a read of 0x30 queued behind it
//   -> the write commits first and the read returns the new data; app_rdy drops when 4 commands are pending.
// - 8 back-to-back reads of addrs 0x00, 0x08 .. 0x38 -> 8 consecutive valid cycles, in order, app_rd_data_end = valid.
// - STALL_PERIOD=16 -> app_rdy low on exactly 1 of every 16 cycles.
// - Reset mid-read -> valid is 0 and no stale data is emitted after recalibration.

Source files
------------

// File: rtl/gba_io_mig_pkg.sv
// rtl/gba_io_mig_pkg.sv - shared MIG UI constants and types for the BRAM responder
package gba_io_mig_pkg;
  localparam int ADDR_WIDTH     = 29;
  localparam int APP_DATA_WIDTH = 128;
  localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic {
    ST_CALIB = 1'b0,
    ST_RUN   = 1'b1
  } calib_state_e;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; full/empty derived from an occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/mig_ui_responder.sv
// rtl/mig_ui_responder.sv - BRAM-backed stand-in for the MIG 7-series app_* interface
module mig_ui_responder #(
  parameter int ADDR_WIDTH     = 29,
  parameter int APP_DATA_WIDTH = 128,
  parameter int DEPTH_LOG2     = 10,
  parameter int CALIB_CYCLES   = 64,
  parameter int RD_LATENCY     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int STALL_PERIOD   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       app_addr,
  input  logic [2:0]                  app_cmd,
  input  logic                        app_en,
  output logic                        app_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  output logic                        app_wdf_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        init_calib_complete
);
  import gba_io_mig_pkg::*;

  localparam int MASK_W  = APP_DATA_WIDTH / 8;
  localparam int LINES   = 1 << DEPTH_LOG2;
  localparam int CMD_W   = 3 + DEPTH_LOG2;
  localparam int WDF_W   = MASK_W + APP_DATA_WIDTH;
  localparam int CALIB_W = $clog2(CALIB_CYCLES + 1);
  localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  calib_state_e       state_q, state_d;
  logic [CALIB_W-1:0] calib_cnt_q, calib_cnt_d;
  logic               run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CALIB;
      calib_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    if (state_q == ST_CALIB) begin
      if (calib_cnt_q == CALIB_W'(CALIB_CYCLES - 1)) state_d = ST_RUN;
      else calib_cnt_d = calib_cnt_q + CALIB_W'(1);
    end
  end

  assign run                 = (state_q == ST_RUN);
  assign init_calib_complete = run;

  // Refresh emulation: one dead app_rdy cycle per STALL_PERIOD while running
  logic [STALL_W-1:0] stall_cnt_q;
  logic               stall;

  assign stall = (STALL_PERIOD != 0) && (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else if (run && STALL_PERIOD != 0) stall_cnt_q <= stall ? '0 : stall_cnt_q + STALL_W'(1);
  end

  logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_W-1:0]      cmd_dout;
  logic                  wdf_push, wdf_pop, wdf_full, wdf_empty;
  logic [WDF_W-1:0]      wdf_dout;
  logic [2:0]            head_cmd;
  logic [DEPTH_LOG2-1:0] head_line;
  logic [MASK_W-1:0]     wdf_mask;
  logic [APP_DATA_WIDTH-1:0] wdf_data;

  assign app_rdy     = run && !cmd_full && !stall;
  assign app_wdf_rdy = run && !wdf_full;
  assign cmd_push    = app_en && app_rdy;
  assign wdf_push    = app_wdf_wren && app_wdf_rdy;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (cmd_push),
    .din_i   ({app_cmd, app_addr[DEPTH_LOG2+2:3]}),
    .pop_i   (cmd_pop),
    .dout_o  (cmd_dout),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  sync_fifo #(.WIDTH(WDF_W), .DEPTH(FIFO_DEPTH)) u_wdf_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (wdf_push),
    .din_i   ({app_wdf_mask, app_wdf_data}),
    .pop_i   (wdf_pop),
    .dout_o  (wdf_dout),
    .full_o  (wdf_full),
    .empty_o (wdf_empty)
  );

  assign {head_cmd, head_line} = cmd_dout;
  assign {wdf_mask, wdf_data}  = wdf_dout;

  logic unused_inputs;
  assign unused_inputs = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

  // A write at the head waits for its data, holding back every command behind it
  logic exec_rd, exec_wr;

  always_comb begin
    exec_rd = 1'b0;
    exec_wr = 1'b0;
    cmd_pop = 1'b0;
    wdf_pop = 1'b0;
    if (run && !cmd_empty) begin
      case (head_cmd)
        MIG_CMD_READ: begin
          cmd_pop = 1'b1;
          exec_rd = 1'b1;
        end
        MIG_CMD_WRITE: begin
          if (!wdf_empty) begin
            cmd_pop = 1'b1;
            wdf_pop = 1'b1;
            exec_wr = 1'b1;
          end
        end
        default: cmd_pop = 1'b1;
      endcase
    end
  end

  logic [APP_DATA_WIDTH-1:0] mem [LINES];
  logic [APP_DATA_WIDTH-1:0] bram_rd_q;

  always_ff @(posedge clk) begin
    if (exec_wr) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (!wdf_mask[i]) mem[head_line][8*i +: 8] <= wdf_data[8*i +: 8];
      end
    end
    if (exec_rd) bram_rd_q <= mem[head_line];
  end

  // Stage 0 is the BRAM output register; later stages carry its data to the port
  logic [RD_LATENCY-1:0]     rd_vld_q;
  logic [APP_DATA_WIDTH-1:0] rd_pipe_q [1:RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q <= '0;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe_q[i] <= '0;
    end else begin
      rd_vld_q     <= {rd_vld_q[RD_LATENCY-2:0], exec_rd};
      rd_pipe_q[1] <= bram_rd_q;
      for (int i = 2; i < RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign app_rd_data       = rd_pipe_q[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
endmodule
